// File: rtl/sonic_lc_adapter_pkg.sv
// Shared constants and payload type for the loopback LC merger skid adapter.
package sonic_lc_adapter_pkg;

  localparam int unsigned DATA_W_DEF = 72;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned STATS_W    = 16;

  typedef logic [DATA_W_DEF-1:0] payload_t;

endpackage

// File: rtl/sonic_lc_drop_stats.sv
// Sticky overflow flag and saturating dropped-beat counter.
module sonic_lc_drop_stats
  import sonic_lc_adapter_pkg::*;
#(
  parameter int unsigned W = STATS_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         drop,
  input  logic         clear,
  output logic         overflow,
  output logic [W-1:0] drop_count
);

  // Clear wins over accumulation but still records a drop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= drop;
      drop_count <= W'(drop);
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {W{1'b1}}) drop_count <= drop_count + W'(1);
    end
  end

endmodule

// File: rtl/sonic_eth_loopback_lc_merger_skid_adapter.sv
// Show-ahead skid buffer between a non-stallable upstream and a ready/valid
// downstream; beats arriving while full with no pop are dropped and counted.
// Optional statistics: define SONIC_LC_MERGER_STATS_EN to enable drop_count
// and clear_stats (overflow is always present, reset-cleared otherwise).
module sonic_eth_loopback_lc_merger_skid_adapter
  import sonic_lc_adapter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AFULL_TH = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               almost_full,
  output logic               overflow,
  output logic [STATS_W-1:0] drop_count,
  input  logic               clear_stats
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;

  // Occupancy decode and handshake qualification.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = !empty && out_ready;
    push       = in_valid && (!full || pop);
    drop       = in_valid && full && !pop;
    count      = wr_ptr - rd_ptr;
    count_next = count + PW'(push) - PW'(pop);
  end

  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  // Pointer and almost_full registers; pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      almost_full <= (32'(count_next) >= AFULL_TH);
    end
  end

  // Storage array, cleared on reset so no stale payload is ever visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

`ifdef SONIC_LC_MERGER_STATS_EN
  sonic_lc_drop_stats #(.W(STATS_W)) u_drop_stats (
    .clk        (clk),
    .reset_n    (reset_n),
    .drop       (drop),
    .clear      (clear_stats),
    .overflow   (overflow),
    .drop_count (drop_count)
  );
`else
  logic ovf_q;
  logic unused_clear_stats;

  // Sticky overflow only; cleared exclusively by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign overflow           = ovf_q;
  assign drop_count         = '0;
  assign unused_clear_stats = clear_stats;
`endif

endmodule

// File: tb/tb_sonic_eth_loopback_lc_merger_skid_adapter.sv
// Randomized and directed self-checking bench with a queue-based model.
module tb_sonic_eth_loopback_lc_merger_skid_adapter;

  localparam int unsigned DATA_W   = 72;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AFULL_TH = 6;
`ifdef SONIC_LC_MERGER_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              almost_full;
  logic              overflow;
  logic [15:0]       drop_count;
  logic              clear_stats;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mq[$];
  logic              m_ovf;
  logic [15:0]       m_cnt;

  sonic_eth_loopback_lc_merger_skid_adapter #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .clear_stats (clear_stats)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_cnt();
    return STATS_EN ? m_cnt : 16'h0;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
    bit pop, full, drop;
    in_valid = v; in_data = d; out_ready = r; clear_stats = c;
    @(posedge clk);
    pop  = (mq.size() != 0) && r;
    full = (mq.size() == DEPTH);
    drop = v && full && !pop;
    if (pop) void'(mq.pop_front());
    if (v && (!full || pop)) mq.push_back(d);
    if (STATS_EN && c) begin
      m_ovf = drop;
      m_cnt = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_stats = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_cnt = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count got %h exp 0", drop_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_single_beat();
    logic [DATA_W-1:0] d;
    d = 72'h0123_4567_89AB_CDEF_11;
    cycle(1'b1, d, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== d) begin errors++; $display("FAIL single_data got %h exp %h", out_data, d); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_low got %b exp 0", out_valid); end
  endtask

  task automatic test_fill_and_drop();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
      checks++;
      if (almost_full !== (i >= int'(AFULL_TH))) begin
        errors++; $display("FAIL fill_almost_full beat %0d got %b exp %b", i, almost_full, (i >= int'(AFULL_TH)));
      end
    end
    cycle(1'b1, DATA_W'(9), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
    checks++; if (drop_count !== exp_cnt()) begin errors++; $display("FAIL fill_drop_count got %h exp %h", drop_count, exp_cnt()); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin
        errors++; $display("FAIL drain_order idx %0d got v=%b d=%h exp d=%h", i, out_valid, out_data, DATA_W'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] cnt_before;
    for (int i = 1; i <= 8; i++) cycle(1'b1, DATA_W'(100 + i), 1'b0, 1'b0);
    cnt_before = drop_count;
    cycle(1'b1, DATA_W'(200), 1'b1, 1'b0);
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL pushpop_almost_full got %b exp 1", almost_full); end
    checks++; if (out_data !== DATA_W'(102)) begin errors++; $display("FAIL pushpop_head got %h exp %h", out_data, DATA_W'(102)); end
    checks++; if (drop_count !== cnt_before || drop_count !== exp_cnt()) begin
      errors++; $display("FAIL pushpop_drop_count got %h exp %h", drop_count, exp_cnt());
    end
    while (mq.size() != 0) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== mq[0]) begin
        errors++; $display("FAIL pushpop_drain got v=%b d=%h exp d=%h", out_valid, out_data, mq[0]);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_saturate_and_clear();
    for (int i = 1; i <= 8; i++) cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    checks++; if (drop_count !== exp_cnt()) begin errors++; $display("FAIL sat_drop_count got %h exp %h", drop_count, exp_cnt()); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got %b exp 1", overflow); end
    cycle(1'b1, rnd_data(), 1'b0, 1'b1);
    checks++; if (drop_count !== (STATS_EN ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL clear_drop_count got %h exp %h", drop_count, (STATS_EN ? 16'd1 : 16'd0));
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clear_overflow got %b exp 1", overflow); end
    while (mq.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_traffic();
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_cnt = 16'h0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL midreset_data got %h exp 0", out_data); end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'h0) begin
      errors++; $display("FAIL midreset_stats got ovf=%b cnt=%h exp 0/0", overflow, drop_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_beat cycle %0d got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_first_push_after_reset();
    logic [DATA_W-1:0] d;
    reset_n = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_cnt = 16'h0;
    @(negedge clk);
    reset_n = 1'b1;
    d = rnd_data();
    cycle(1'b1, d, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== d) begin
      errors++; $display("FAIL first_push got v=%b d=%h exp d=%h", out_valid, out_data, d);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      checks++;
      if (out_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, out_valid, (mq.size() != 0));
      end else if (out_valid && out_data !== mq[0]) begin
        errors++; $display("FAIL rand_data cyc %0d got %h exp %h", i, out_data, mq[0]);
      end
      checks++;
      if (almost_full !== (mq.size() >= AFULL_TH)) begin
        errors++; $display("FAIL rand_almost_full cyc %0d got %b exp %b", i, almost_full, (mq.size() >= AFULL_TH));
      end
      checks++;
      if (overflow !== m_ovf || drop_count !== exp_cnt()) begin
        errors++; $display("FAIL rand_stats cyc %0d got ovf=%b cnt=%h exp ovf=%b cnt=%h", i, overflow, drop_count, m_ovf, exp_cnt());
      end
      cycle(($urandom_range(99) < 50), rnd_data(), ($urandom_range(99) < 30), ($urandom_range(999) < 5));
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_beat();
    test_fill_and_drop();
    test_full_push_pop();
    test_saturate_and_clear();
    test_reset_mid_traffic();
    test_first_push_after_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_eth_loopback_lc_merger_skid_adapter.md
SONIC_ETH_LOOPBACK_LC_MERGER_SKID_ADAPTER -- requirements
Module: sonic_eth_loopback_lc_merger_skid_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 72, meaning payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning skid buffer entries; power of two, range 2..64.
REQ-003 SHALL have parameter AFULL_TH, default 6, meaning occupancy at or above which almost_full asserts.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_data  input  DATA_W  upstream payload; upstream cannot be backpressured.
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port out_data  output  DATA_W  head-of-buffer payload.
REQ-009 SHALL have port out_valid  output  1  head entry valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; ready latency 0.
REQ-011 SHALL have port almost_full  output  1  occupancy >= AFULL_TH.
REQ-012 SHALL have port overflow  output  1  sticky: at least one beat dropped since reset or clear.
REQ-013 SHALL have port drop_count  output  16  saturating count of dropped beats.
REQ-014 SHALL have port clear_stats  input  1  one-cycle pulse clearing overflow and drop_count.

Function
REQ-015 SHALL implement a show-ahead FIFO: out_valid = (occupancy != 0), out_data = storage[rd_ptr].
REQ-016 SHALL pop on out_valid & out_ready; SHALL ignore out_ready while out_valid = 0.
REQ-017 SHALL push on in_valid when not full, or when full and a pop occurs in the same cycle.
REQ-018 Latency SHALL be 1 cycle: beat pushed into an empty buffer at edge N gives out_valid = 1 after edge N.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-020 Pointers SHALL be log2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-021 Occupancy SHALL range 0..DEPTH; no other values reachable.
REQ-022 in_valid while full with no pop SHALL discard the beat, leave the buffer unchanged, set overflow, and increment drop_count.
REQ-023 drop_count SHALL saturate at 16'hFFFF.
REQ-024 clear_stats SHALL zero overflow and drop_count on the next edge; a drop in the same cycle SHALL give overflow = 1 and drop_count = 1.
REQ-025 almost_full SHALL be registered and reflect post-edge occupancy.

Reset
REQ-026 Asserting reset_n low SHALL immediately clear pointers, occupancy, storage, overflow and drop_count; out_valid = 0, out_data = 0, almost_full = 0.
REQ-027 Reset mid-traffic SHALL discard all buffered beats; no partial beat SHALL emerge after release.
REQ-028 First push SHALL be accepted on the first rising edge with reset_n high.

Configuration
REQ-029 Macro SONIC_LC_MERGER_STATS_EN defined: overflow, drop_count and clear_stats SHALL behave per REQ-022..024.
REQ-030 Macro undefined: drop_count SHALL be constant 0 and clear_stats ignored; overflow SHALL still be implemented, cleared only by reset; drops SHALL still occur.

Structure
REQ-031 Package sonic_lc_adapter_pkg SHALL hold DATA_W default, DEPTH default, the 16-bit stats width constant, and the payload typedef.
REQ-032 Saturating counter and overflow flag SHALL be a sub-module named sonic_lc_drop_stats, instantiated only under SONIC_LC_MERGER_STATS_EN.

Verification
REQ-033 Empty buffer, one in_valid beat 72'h0123_4567_89AB_CDEF_11, out_ready = 1 -> out_valid high exactly one cycle later with that data, then low.
REQ-034 out_ready = 0, 8 beats 1..8 -> almost_full after 6th, full after 8th; 9th beat dropped, overflow = 1, drop_count = 1; release -> 1..8 in order.
REQ-035 Full buffer, in_valid and out_ready in the same cycle -> new beat accepted, head popped, occupancy stays 8, drop_count unchanged.
REQ-036 Hold full and drive 70000 drops -> drop_count = 16'hFFFF; clear_stats together with one drop -> drop_count = 1, overflow = 1.
REQ-037 Reset_n low with 5 beats buffered -> out_valid = 0 immediately; after release no stale beat appears.
REQ-038 Random in_valid (50%) and out_ready (30%), 10k cycles -> scoreboard: accepted beats emerge in order, drop_count equals scoreboard drops.
